// File: rtl/core_pkg.sv
// Shared fetch/decode types: immediate formats, major opcodes and realignment residue states.
package core_pkg;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned HLEN  = 16;
    localparam int unsigned OPC_W = 5;

    typedef enum logic [3:0] {
        IMM_I    = 4'd0,
        IMM_S    = 4'd1,
        IMM_B    = 4'd2,
        IMM_U    = 4'd3,
        IMM_J    = 4'd4,
        IMM_CI   = 4'd5,
        IMM_CIW  = 4'd6,
        IMM_CLUI = 4'd7,
        IMM_CSPL = 4'd8,
        IMM_CSPS = 4'd9,
        IMM_CLS  = 4'd10,
        IMM_CB   = 4'd11,
        IMM_CJ   = 4'd12,
        IMM_CJR  = 4'd13
    } immediate_source_t;

    typedef enum logic [1:0] {
        RES_EMPTY   = 2'd0,
        RES_UPPER32 = 2'd1,
        RES_C16     = 2'd2
    } align_state_t;

    // Major opcodes, instr[6:2]
    localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_STORE    = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_LUI      = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR     = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL      = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 5'b11100;

endpackage

// File: rtl/imm_fmt_select.sv
// Combinational immediate format classification and sign-extended extraction.
// Compressed formats are decoded only when COMPRESSED_EN is defined.
module imm_fmt_select
    import core_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [31:0]        instr_i,
    input  logic               compressed_i,
    output immediate_source_t  imm_type_o,
    output logic [DWIDTH-1:0]  imm_o
);

    logic [31:0] imm32;
    logic        unused_low;

    assign unused_low = ^instr_i[1:0];

    always_comb begin
        imm_type_o = IMM_I;
        imm32      = '0;
        if (!compressed_i) begin
            case (instr_i[6:2])
                OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM: begin
                    imm_type_o = IMM_I;
                    imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                OPC_STORE: begin
                    imm_type_o = IMM_S;
                    imm32      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                OPC_BRANCH: begin
                    imm_type_o = IMM_B;
                    imm32      = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                                  instr_i[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_type_o = IMM_U;
                    imm32      = {instr_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    imm_type_o = IMM_J;
                    imm32      = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                                  instr_i[30:21], 1'b0};
                end
                default: ;
            endcase
        end else begin
`ifdef COMPRESSED_EN
            // Keyed by {quadrant, funct3}
            case ({instr_i[1:0], instr_i[15:13]})
                5'b00_000: begin
                    imm_type_o = IMM_CIW;
                    imm32      = {22'b0, instr_i[10:7], instr_i[12:11], instr_i[5],
                                  instr_i[6], 2'b00};
                end
                5'b00_010, 5'b00_110: begin
                    imm_type_o = IMM_CLS;
                    imm32      = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
                end
                5'b01_000, 5'b01_010, 5'b10_000: begin
                    imm_type_o = IMM_CI;
                    imm32      = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
                end
                5'b01_001, 5'b01_101: begin
                    imm_type_o = IMM_CJ;
                    imm32      = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9],
                                  instr_i[6], instr_i[7], instr_i[2], instr_i[11],
                                  instr_i[5:3], 1'b0};
                end
                5'b01_011: begin
                    // rd==x2 is C.ADDI16SP, which has no format of its own here
                    if (instr_i[11:7] != 5'd2) begin
                        imm_type_o = IMM_CLUI;
                        imm32      = {{14{instr_i[12]}}, instr_i[12], instr_i[6:2], 12'b0};
                    end
                end
                5'b01_100: begin
                    if (instr_i[11:10] != 2'b11) begin
                        imm_type_o = IMM_CI;
                        imm32      = {{26{instr_i[12]}}, instr_i[12], instr_i[6:2]};
                    end
                end
                5'b01_110, 5'b01_111: begin
                    imm_type_o = IMM_CB;
                    imm32      = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                                  instr_i[11:10], instr_i[4:3], 1'b0};
                end
                5'b10_010: begin
                    imm_type_o = IMM_CSPL;
                    imm32      = {24'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00};
                end
                5'b10_100: begin
                    if (instr_i[6:2] == 5'd0 && instr_i[11:7] != 5'd0) begin
                        imm_type_o = IMM_CJR;
                    end
                end
                5'b10_110: begin
                    imm_type_o = IMM_CSPS;
                    imm32      = {24'b0, instr_i[8:7], instr_i[12:9], 2'b00};
                end
                default: ;
            endcase
`endif
        end
    end

    assign imm_o = DWIDTH'($signed(imm32));

endmodule

// File: rtl/instr_align_imm.sv
// Fetch-word realigner: emits whole 16/32-bit instructions with PC and decoded immediate.
// COMPRESSED_EN enables halfword realignment; otherwise each word is one 32-bit instruction.
module instr_align_imm
    import core_pkg::*;
#(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                fetch_valid_i,
    output logic                fetch_ready_o,
    input  logic [31:0]         fetch_data_i,
    input  logic [PC_WIDTH-1:0] fetch_addr_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] instr_pc_o,
    output logic                instr_compressed_o,
    output immediate_source_t   imm_type_o,
    output logic [DWIDTH-1:0]   imm_o
);

    generate
        if (DWIDTH != 32 && DWIDTH != 64) begin : g_bad_dwidth
            $error("instr_align_imm: DWIDTH must be 32 or 64");
        end
    endgenerate

    logic                out_free;
    logic                emit;
    logic [ILEN-1:0]     emit_instr;
    logic [PC_WIDTH-1:0] emit_pc;
    logic                emit_c;
    logic [PC_WIDTH-1:0] pc_lo;
    immediate_source_t   sel_type;
    logic [DWIDTH-1:0]   sel_imm;

    logic                valid_q;
    logic [ILEN-1:0]     instr_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                c_q;
    immediate_source_t   type_q;
    logic [DWIDTH-1:0]   imm_q;

    assign out_free = !valid_q || instr_ready_i;
    assign pc_lo    = fetch_addr_i & ~PC_WIDTH'(2);

`ifdef COMPRESSED_EN
    align_state_t        state_q, state_d;
    logic [HLEN-1:0]     res_q, res_d;
    logic [PC_WIDTH-1:0] res_pc_q, res_pc_d;
    logic [PC_WIDTH-1:0] pc_hi;
    logic                word_acc;

    assign pc_hi         = pc_lo + PC_WIDTH'(2);
    assign fetch_ready_o = out_free && (state_q != RES_C16) && !flush_i;
    assign word_acc      = fetch_valid_i && fetch_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= RES_EMPTY;
            res_q    <= '0;
            res_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_pc_q <= res_pc_d;
        end
    end

    // Residue next-state and emitted instruction select
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        res_pc_d   = res_pc_q;
        emit       = 1'b0;
        emit_instr = '0;
        emit_pc    = '0;
        emit_c     = 1'b0;
        if (flush_i) begin
            state_d = RES_EMPTY;
        end else if (out_free) begin
            case (state_q)
                RES_C16: begin
                    emit       = 1'b1;
                    emit_instr = {16'b0, res_q};
                    emit_pc    = res_pc_q;
                    emit_c     = 1'b1;
                    state_d    = RES_EMPTY;
                end
                RES_UPPER32: begin
                    if (word_acc) begin
                        emit       = 1'b1;
                        emit_instr = {fetch_data_i[15:0], res_q};
                        emit_pc    = res_pc_q;
                        res_d      = fetch_data_i[31:16];
                        res_pc_d   = pc_hi;
                        state_d    = (fetch_data_i[17:16] == 2'b11) ? RES_UPPER32 : RES_C16;
                    end
                end
                default: begin
                    if (word_acc) begin
                        if (fetch_addr_i[1]) begin
                            if (fetch_data_i[17:16] != 2'b11) begin
                                emit       = 1'b1;
                                emit_instr = {16'b0, fetch_data_i[31:16]};
                                emit_pc    = pc_hi;
                                emit_c     = 1'b1;
                            end else begin
                                res_d    = fetch_data_i[31:16];
                                res_pc_d = pc_hi;
                                state_d  = RES_UPPER32;
                            end
                        end else if (fetch_data_i[1:0] != 2'b11) begin
                            emit       = 1'b1;
                            emit_instr = {16'b0, fetch_data_i[15:0]};
                            emit_pc    = pc_lo;
                            emit_c     = 1'b1;
                            res_d      = fetch_data_i[31:16];
                            res_pc_d   = pc_hi;
                            state_d    = (fetch_data_i[17:16] == 2'b11) ? RES_UPPER32 : RES_C16;
                        end else begin
                            emit       = 1'b1;
                            emit_instr = fetch_data_i;
                            emit_pc    = pc_lo;
                        end
                    end
                end
            endcase
        end
    end
`else
    assign fetch_ready_o = out_free && !flush_i;

    always_comb begin
        emit       = fetch_valid_i && fetch_ready_o;
        emit_instr = fetch_data_i;
        emit_pc    = pc_lo;
        emit_c     = 1'b0;
    end
`endif

    imm_fmt_select #(
        .DWIDTH (DWIDTH)
    ) u_imm_fmt_select (
        .instr_i      (emit_instr),
        .compressed_i (emit_c),
        .imm_type_o   (sel_type),
        .imm_o        (sel_imm)
    );

    // Output stage: flush wins over any pop or load
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            c_q     <= 1'b0;
            type_q  <= IMM_I;
            imm_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (out_free) begin
            valid_q <= emit;
            if (emit) begin
                instr_q <= emit_instr;
                pc_q    <= emit_pc;
                c_q     <= emit_c;
                type_q  <= sel_type;
                imm_q   <= sel_imm;
            end
        end
    end

    assign instr_valid_o      = valid_q;
    assign instr_o            = instr_q;
    assign instr_pc_o         = pc_q;
    assign instr_compressed_o = c_q;
    assign imm_type_o         = type_q;
    assign imm_o              = imm_q;

endmodule

// File: tb/tb_instr_align_imm.sv
// Directed bench for instr_align_imm; compressed realignment vectors run when COMPRESSED_EN is defined.
module tb_instr_align_imm;
    import core_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [31:0]       fetch_data;
    logic [PW-1:0]     fetch_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [PW-1:0]     instr_pc;
    logic              instr_c;
    immediate_source_t imm_type;
    logic [DW-1:0]     imm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_align_imm #(
        .DWIDTH   (DW),
        .PC_WIDTH (PW)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .flush_i            (flush),
        .fetch_valid_i      (fetch_valid),
        .fetch_ready_o      (fetch_ready),
        .fetch_data_i       (fetch_data),
        .fetch_addr_i       (fetch_addr),
        .instr_valid_o      (instr_valid),
        .instr_ready_i      (instr_ready),
        .instr_o            (instr),
        .instr_pc_o         (instr_pc),
        .instr_compressed_o (instr_c),
        .imm_type_o         (imm_type),
        .imm_o              (imm)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        if (DW == 64) return {{32{v[31]}}, v};
        return {32'b0, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [PW-1:0] a);
        fetch_valid = v;
        fetch_data  = d;
        fetch_addr  = a;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] ins, input logic [PW-1:0] pc,
                             input logic c, input immediate_source_t t, input logic [63:0] im);
        check({tag, ".valid"}, 64'(instr_valid), 64'd1);
        check({tag, ".instr"}, 64'(instr), 64'(ins));
        check({tag, ".pc"}, 64'(instr_pc), 64'(pc));
        check({tag, ".cflag"}, 64'(instr_c), 64'(c));
        check({tag, ".type"}, 64'(imm_type), 64'(t));
        check({tag, ".imm"}, 64'(imm), im);
    endtask

    task automatic run32(input string tag, input logic [31:0] ins, input logic [PW-1:0] a,
                         input immediate_source_t t, input logic [31:0] im);
        drive(1'b1, ins, a);
        check({tag, ".ready"}, 64'(fetch_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out(tag, ins, a, 1'b0, t, sx(im));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        fetch_addr  = '0;
        instr_ready = 1'b1;
        #12;
        check("rst.valid", 64'(instr_valid), 64'd0);
        check("rst.instr", 64'(instr), 64'd0);
        check("rst.pc", 64'(instr_pc), 64'd0);
        check("rst.cflag", 64'(instr_c), 64'd0);
        check("rst.type", 64'(imm_type), 64'(IMM_I));
        check("rst.imm", 64'(imm), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.ready", 64'(fetch_ready), 64'd1);

        // Aligned 32-bit instructions, back to back
        run32("addi", 32'hFFF00093, 32'h100, IMM_I, 32'hFFFFFFFF);
        run32("sw",   32'hFE512E23, 32'h104, IMM_S, 32'hFFFFFFFC);
        run32("beq",  32'hFE000FE3, 32'h108, IMM_B, 32'hFFFFFFFE);
        run32("lui",  32'h800000B7, 32'h10C, IMM_U, 32'h80000000);
        run32("jal",  32'hFFDFF0EF, 32'h110, IMM_J, 32'hFFFFFFFC);
        run32("add",  32'h003100B3, 32'h114, IMM_I, 32'h0);
        tick();
        check("idle.valid", 64'(instr_valid), 64'd0);

        // Backpressure: output held, next word waits
        instr_ready = 1'b0;
        drive(1'b1, 32'hFE512E23, 32'h600);
        tick();
        drive(1'b1, 32'hFE000FE3, 32'h604);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold%0d.valid", i), 64'(instr_valid), 64'd1);
            check($sformatf("hold%0d.instr", i), 64'(instr), 64'hFE512E23);
            check($sformatf("hold%0d.ready", i), 64'(fetch_ready), 64'd0);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        check("hold.release_ready", 64'(fetch_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("hold.next", 32'hFE000FE3, 32'h604, 1'b0, IMM_B, sx(32'hFFFFFFFE));
        tick();
        check("hold.drain", 64'(instr_valid), 64'd0);

        // Flush kills a stalled output and refuses the presented word
        drive(1'b1, 32'hFE512E23, 32'h700);
        tick();
        check("fl.pre_valid", 64'(instr_valid), 64'd1);
        instr_ready = 1'b0;
        flush       = 1'b1;
        drive(1'b1, 32'h800000B7, 32'h704);
        check("fl.ready", 64'(fetch_ready), 64'd0);
        tick();
        flush       = 1'b0;
        instr_ready = 1'b1;
        drive(1'b0, 32'h0, '0);
        check("fl.valid", 64'(instr_valid), 64'd0);
        tick();
        check("fl.not_taken", 64'(instr_valid), 64'd0);

`ifdef COMPRESSED_EN
        // Two compressed instructions in one word
        drive(1'b1, 32'h000150FD, 32'h100);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("c2a", 32'h000050FD, 32'h100, 1'b1, IMM_CI, sx(32'hFFFFFFFF));
        check("c2a.ready", 64'(fetch_ready), 64'd0);
        tick();
        check_out("c2b", 32'h00000001, 32'h102, 1'b1, IMM_CI, 64'd0);
        tick();
        check("c2.drain", 64'(instr_valid), 64'd0);

        // 32-bit instruction straddling two words
        drive(1'b1, 32'h00930001, 32'h200);
        tick();
        drive(1'b1, 32'h0001FFF0, 32'h204);
        check_out("st0", 32'h00000001, 32'h200, 1'b1, IMM_CI, 64'd0);
        check("st0.ready", 64'(fetch_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("st1", 32'hFFF00093, 32'h202, 1'b0, IMM_I, sx(32'hFFFFFFFF));
        tick();
        check_out("st2", 32'h00000001, 32'h206, 1'b1, IMM_CI, 64'd0);
        tick();
        check("st.drain", 64'(instr_valid), 64'd0);

        // Jump into the upper halfword
        drive(1'b1, 32'h50FD0093, 32'h402);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("jmp", 32'h000050FD, 32'h402, 1'b1, IMM_CI, sx(32'hFFFFFFFF));
        tick();
        check("jmp.drain", 64'(instr_valid), 64'd0);

        // Flush while a straddle is pending drops the residue
        drive(1'b1, 32'h00930001, 32'h200);
        tick();
        check_out("fs0", 32'h00000001, 32'h200, 1'b1, IMM_CI, 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00000013, 32'h300);
        check("fs.ready", 64'(fetch_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fs.valid", 64'(instr_valid), 64'd0);
        check("fs.ready_after", 64'(fetch_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("fs1", 32'h00000013, 32'h300, 1'b0, IMM_I, 64'd0);
        tick();
        check("fs.drain", 64'(instr_valid), 64'd0);

        // Compressed load/store/jump formats
        drive(1'b1, 32'hDF824040, 32'h500);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("clw", 32'h00004040, 32'h500, 1'b1, IMM_CLS, 64'd4);
        tick();
        check_out("cswsp", 32'h0000DF82, 32'h502, 1'b1, IMM_CSPS, 64'hFC);
        drive(1'b1, 32'h0001BFFD, 32'h504);
        check("cj.ready", 64'(fetch_ready), 64'd1);
        tick();
        drive(1'b0, 32'h0, '0);
        check_out("cj", 32'h0000BFFD, 32'h504, 1'b1, IMM_CJ, sx(32'hFFFFFFFE));
        tick();
        check_out("cnop", 32'h00000001, 32'h506, 1'b1, IMM_CI, 64'd0);
        tick();
        check("cj.drain", 64'(instr_valid), 64'd0);
`else
        // Without realignment a word with compressed encodings is one 32-bit instruction
        run32("whole", 32'h000150FD, 32'h100, IMM_I, 32'h0);
        tick();
        check("whole.drain", 64'(instr_valid), 64'd0);
        check("whole.ready", 64'(fetch_ready), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
